// File: rtl/stage_tracker_pkg.sv
// Shared types for the per-stage trace tracker: trace element, stage selector,
// head FSM states and the stage timestamp helper.
package stage_tracker_pkg;

  localparam int unsigned TIME_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned INSN_W = 32;

  typedef enum logic [1:0] {
    STAGE_IF,
    STAGE_ID,
    STAGE_EX,
    STAGE_WB
  } stage_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_ACTIVE,
    ST_HOLD
  } head_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] instr;
    logic [TIME_W-1:0] if_start;
    logic [TIME_W-1:0] if_end;
    logic [TIME_W-1:0] id_start;
    logic [TIME_W-1:0] id_end;
    logic [TIME_W-1:0] ex_start;
    logic [TIME_W-1:0] ex_end;
    logic [TIME_W-1:0] wb_start;
    logic [TIME_W-1:0] wb_end;
  } trace_output;

  // Returns elem with only the selected stage's start or end field replaced.
  function automatic trace_output set_stage_time(trace_output       elem,
                                                 stage_e            stage,
                                                 logic              is_end,
                                                 logic [TIME_W-1:0] value);
    trace_output r;
    r = elem;
    case (stage)
      STAGE_IF: if (is_end) r.if_end = value; else r.if_start = value;
      STAGE_ID: if (is_end) r.id_end = value; else r.id_start = value;
      STAGE_EX: if (is_end) r.ex_end = value; else r.ex_start = value;
      STAGE_WB: if (is_end) r.wb_end = value; else r.wb_start = value;
      default: r = elem;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage_tracker_if.sv
// Upstream push and downstream valid/ready handshake of one stage tracker.
interface stage_tracker_if;
  import stage_tracker_pkg::*;

  logic        in_valid;
  trace_output in_data;
  logic        in_ready;
  logic        out_valid;
  trace_output out_data;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stage_tracker_fifo.sv
// Trace element FIFO with head and head+1 read/patch ports; wrap-bit pointers.
module trace_fifo
  import stage_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  trace_output              push_data_i,
  input  logic                     pop_i,
  input  logic                     head_we_i,
  input  trace_output              head_wdata_i,
  input  logic                     next_we_i,
  input  trace_output              next_wdata_i,
  output trace_output              head_o,
  output trace_output              next_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] wr_idx, rd_idx, nx_idx;
  trace_output   mem_q [DEPTH];

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign nx_idx  = rd_idx + AW'(1);
  assign head_o  = mem_q[rd_idx];
  assign next_o  = mem_q[nx_idx];
  assign count_o = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Push never targets head or head+1 while they are being patched: a push
  // needs a free slot, and head+1 is only patched when two entries are held.
  always_ff @(posedge clk) begin
    if (push_i)    mem_q[wr_idx] <= push_data_i;
    if (head_we_i) mem_q[rd_idx] <= head_wdata_i;
    if (next_we_i) mem_q[nx_idx] <= next_wdata_i;
  end

endmodule

// File: rtl/stage_tracker.sv
// Buffered trace tracker for one pipeline stage: queues upstream elements,
// stamps the selected stage's entry/exit times and hands them downstream.
module stage_tracker
  import stage_tracker_pkg::*;
#(
  parameter stage_e      STAGE         = STAGE_ID,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] counter_i,
  input  logic                     stage_active_i,
  input  logic                     stage_advance_i,
  stage_tracker_if.slave           bus,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o,
  output logic                     missed_start_o
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  head_state_e       state_q, state_d;
  logic              out_valid_q, out_valid_d;
  trace_output       out_data_q, out_data_d;
  logic              adv_q, adv_d;
  logic [TIME_W-1:0] tend_q, tend_d;
  logic              active_q;
  logic              overflow_q, overflow_d;
  logic              missed_q, missed_d;

  logic [CNT_W-1:0]  count;
  trace_output       head, next;
  trace_output       head_wdata, next_wdata;
  trace_output       start_elem, end_elem;
  logic              push, pop, head_we, next_we, chain;
  logic              slot_free, end_evt, adv_end, has_next, empty_after;
  logic [TIME_W-1:0] stamp;

  assign bus.in_ready  = (count != CNT_W'(DEPTH));
  assign push          = bus.in_valid && bus.in_ready;
  assign stamp         = TIME_W'(counter_i);
  assign slot_free     = !out_valid_q || bus.out_ready;
  assign end_evt       = !stage_active_i || stage_advance_i;
  assign adv_end       = stage_advance_i && stage_active_i;
  assign has_next      = (count >= CNT_W'(2));
  assign empty_after   = (count == CNT_W'(1)) && !push;
  assign start_elem    = set_stage_time(head, STAGE, 1'b0, stamp);
  assign end_elem      = set_stage_time(head, STAGE, 1'b1, stamp);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  (bus.in_data),
    .pop_i        (pop),
    .head_we_i    (head_we),
    .head_wdata_i (head_wdata),
    .next_we_i    (next_we),
    .next_wdata_i (next_wdata),
    .head_o       (head),
    .next_o       (next),
    .count_o      (count)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    chain       = 1'b0;
    head_we     = 1'b0;
    head_wdata  = end_elem;
    next_we     = 1'b0;
    next_wdata  = set_stage_time(next, STAGE, 1'b0, stamp);
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    adv_d       = adv_q;
    tend_d      = tend_q;
    overflow_d  = overflow_q || (bus.in_valid && !bus.in_ready);
    missed_d    = missed_q || ((state_q == ST_HOLD) && stage_active_i && !active_q);

    unique case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (stage_active_i) begin
          head_we    = 1'b1;
          head_wdata = start_elem;
          state_d    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (end_evt) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_data_d  = end_elem;
            pop         = 1'b1;
            chain       = adv_end;
          end else begin
            // Park the stamped element in the FIFO head until the slot frees.
            head_we    = 1'b1;
            head_wdata = end_elem;
            adv_d      = adv_end;
            tend_d     = stamp;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = head;
          pop         = 1'b1;
          chain       = adv_q;
          next_wdata  = set_stage_time(next, STAGE, 1'b0, tend_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An advance hands the stage straight to the next queued instruction.
    if (pop) begin
      if (chain && has_next) begin
        next_we = 1'b1;
        state_d = ST_ACTIVE;
      end else if (empty_after) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_WAIT_START;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      adv_q       <= 1'b0;
      tend_q      <= '0;
      active_q    <= 1'b0;
      overflow_q  <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      adv_q       <= adv_d;
      tend_q      <= tend_d;
      active_q    <= stage_active_i;
      overflow_q  <= overflow_d;
      missed_q    <= missed_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign occupancy_o    = count;
  assign overflow_o     = overflow_q;
  assign missed_start_o = missed_q;

endmodule
